// File: rtl/read_burst_sequencer_if.sv
// Burst command and read-return signals between the read sequencer and the AXI read engine.
interface read_burst_sequencer_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8
);
  logic                  start_read;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [LEN_WIDTH-1:0]  rburst;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_ready;
  logic                  read_end;

  modport master (
    output start_read, read_addr, rburst,
    input  read_data, read_ready, read_end
  );

  modport slave (
    input  start_read, read_addr, rburst,
    output read_data, read_ready, read_end
  );
endinterface

// File: rtl/read_burst_sequencer.sv
// Breaks one read job into a strided sequence of fixed-length bursts and tallies the returned beats.
// Define READ_SEQ_CHECKSUM_EN to build the XOR data checksum; otherwise checksum is tied to zero.
module read_burst_sequencer #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_num_bursts,
  input  logic [LEN_WIDTH-1:0]  cfg_burst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [DATA_WIDTH-1:0] checksum,
  read_burst_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic                  r_start_read;
  logic [ADDR_WIDTH-1:0] r_read_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [LEN_WIDTH-1:0]  r_rburst;
  logic [CNT_WIDTH-1:0]  r_num_bursts;
  logic [CNT_WIDTH-1:0]  r_burst_idx;
  logic [CNT_WIDTH-1:0]  r_burst_beats;
  logic [CNT_WIDTH-1:0]  r_beat_count;
  logic [CNT_WIDTH-1:0]  r_cycle_count;

  logic [CNT_WIDTH-1:0]  w_beats_this_burst;
  logic [CNT_WIDTH-1:0]  w_expected_beats;
  logic [CNT_WIDTH-1:0]  w_next_idx;
  logic [CNT_WIDTH-1:0]  w_cycle_next;

  // Beat count for the closing burst includes a beat arriving together with read_end.
  assign w_beats_this_burst = r_burst_beats + CNT_WIDTH'(bus.read_ready);
  assign w_expected_beats   = CNT_WIDTH'(r_rburst) + CNT_WIDTH'(1);
  assign w_next_idx         = r_burst_idx + CNT_WIDTH'(1);
  assign w_cycle_next       = (&r_cycle_count) ? r_cycle_count : r_cycle_count + CNT_WIDTH'(1);

`ifdef READ_SEQ_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  function automatic logic [DATA_WIDTH-1:0] f_fold_beat(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] beat
  );
    return acc ^ beat;
  endfunction

  assign checksum = r_checksum;
`else
  logic w_unused_data;
  assign w_unused_data = ^bus.read_data;
  assign checksum      = {DATA_WIDTH{1'b0}};
`endif

  // Job sequencing FSM with all externally visible results held in registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_start_read  <= 1'b0;
      r_read_addr   <= {ADDR_WIDTH{1'b0}};
      r_stride      <= {ADDR_WIDTH{1'b0}};
      r_rburst      <= {LEN_WIDTH{1'b0}};
      r_num_bursts  <= {CNT_WIDTH{1'b0}};
      r_burst_idx   <= {CNT_WIDTH{1'b0}};
      r_burst_beats <= {CNT_WIDTH{1'b0}};
      r_beat_count  <= {CNT_WIDTH{1'b0}};
      r_cycle_count <= {CNT_WIDTH{1'b0}};
`ifdef READ_SEQ_CHECKSUM_EN
      r_checksum    <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      r_start_read <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_busy        <= 1'b1;
            r_read_addr   <= cfg_base_addr;
            r_stride      <= cfg_stride;
            r_rburst      <= cfg_burst;
            r_num_bursts  <= cfg_num_bursts;
            r_burst_idx   <= {CNT_WIDTH{1'b0}};
            r_burst_beats <= {CNT_WIDTH{1'b0}};
            r_beat_count  <= {CNT_WIDTH{1'b0}};
            r_cycle_count <= {CNT_WIDTH{1'b0}};
            r_error       <= 1'b0;
`ifdef READ_SEQ_CHECKSUM_EN
            r_checksum    <= {DATA_WIDTH{1'b0}};
`endif
            if (cfg_num_bursts == {CNT_WIDTH{1'b0}}) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_start_read <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cycle_count <= w_cycle_next;
          r_state       <= S_WAIT;
        end
        S_WAIT: begin
          r_cycle_count <= w_cycle_next;
          if (bus.read_ready) begin
            r_beat_count <= r_beat_count + CNT_WIDTH'(1);
`ifdef READ_SEQ_CHECKSUM_EN
            r_checksum   <= f_fold_beat(r_checksum, bus.read_data);
`endif
          end
          if (bus.read_end) begin
            if (w_beats_this_burst != w_expected_beats) begin
              r_error <= 1'b1;
            end
            r_burst_beats <= {CNT_WIDTH{1'b0}};
            r_burst_idx   <= w_next_idx;
            if (w_next_idx == r_num_bursts) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              // Address arithmetic wraps naturally at the address width.
              r_read_addr  <= r_read_addr + r_stride;
              r_start_read <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end else if (bus.read_ready) begin
            r_burst_beats <= w_beats_this_burst;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign beat_count     = r_beat_count;
  assign cycle_count    = r_cycle_count;
  assign bus.start_read = r_start_read;
  assign bus.read_addr  = r_read_addr;
  assign bus.rburst     = r_rburst;

endmodule

// File: tb/tb_read_burst_sequencer.sv
// Self-checking bench for read_burst_sequencer: directed jobs plus randomized jobs against a job-level model.
module tb_read_burst_sequencer;
  localparam int AW = 33;
  localparam int DW = 256;
  localparam int LW = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [AW-1:0] cfg_stride = '0;
  logic [CW-1:0] cfg_num_bursts = '0;
  logic [LW-1:0] cfg_burst = '0;
  logic          busy, done, error;
  logic [CW-1:0] beat_count, cycle_count;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fixed_q[$];

  read_burst_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) rd_if ();

  read_burst_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_stride(cfg_stride), .cfg_num_bursts(cfg_num_bursts), .cfg_burst(cfg_burst),
    .busy(busy), .done(done), .error(error), .beat_count(beat_count),
    .cycle_count(cycle_count), .checksum(checksum), .bus(rd_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd256();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] exp_checksum(input logic [DW-1:0] x);
`ifdef READ_SEQ_CHECKSUM_EN
    return x;
`else
    return (x & '0);
`endif
  endfunction

  // Runs one job: the bench plays the engine and predicts every result from the job description.
  task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int nb,
                         input logic [LW-1:0] burst, input int short_idx, input int long_idx,
                         input bit poke);
    logic [AW-1:0] addr;
    logic [DW-1:0] d;
    logic [DW-1:0] sum = '0;
    int nbeats;
    int beats_tot = 0;
    int cyc = 0;
    bit exp_err = 1'b0;
    bit end_with_beat;
    cfg_base_addr  = base;
    cfg_stride     = stride;
    cfg_num_bursts = CW'(nb);
    cfg_burst      = burst;
    cfg_start      = 1'b1;
    step();
    cfg_start = 1'b0;
    if (nb == 0) chk("zero_no_start", rd_if.start_read, 1'b0);
    for (int b = 0; b < nb; b++) begin
      addr = base + AW'(b) * stride;
      chk("start_read", rd_if.start_read, 1'b1);
      chk("read_addr", rd_if.read_addr, addr);
      chk("rburst", rd_if.rburst, burst);
      chk("busy_issue", busy, 1'b1);
      // Stray engine activity in ISSUE must not count.
      rd_if.read_ready = 1'($urandom_range(0, 1));
      rd_if.read_end   = 1'($urandom_range(0, 1));
      rd_if.read_data  = rnd256();
      step();
      cyc++;
      nbeats = int'(burst) + 1 + ((b == long_idx) ? 1 : 0) - ((b == short_idx) ? 1 : 0);
      if (nbeats != int'(burst) + 1) exp_err = 1'b1;
      end_with_beat = (nbeats > 0) && ($urandom_range(0, 1) == 1);
      for (int k = 0; k < nbeats; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          rd_if.read_ready = 1'b0;
          rd_if.read_end   = 1'b0;
          step();
          cyc++;
          chk("no_start_in_wait", rd_if.start_read, 1'b0);
        end
        d = (fixed_q.size() > 0) ? fixed_q.pop_front() : rnd256();
        rd_if.read_ready = 1'b1;
        rd_if.read_data  = d;
        rd_if.read_end   = (k == nbeats - 1) && end_with_beat;
        sum = sum ^ d;
        beats_tot++;
        if (poke && b == 0 && k == 0) begin
          cfg_start      = 1'b1;
          cfg_base_addr  = ~base;
          cfg_num_bursts = '0;
        end
        step();
        cyc++;
        cfg_start      = 1'b0;
        cfg_base_addr  = base;
        cfg_num_bursts = CW'(nb);
      end
      if (!end_with_beat) begin
        rd_if.read_ready = 1'b0;
        rd_if.read_end   = 1'b1;
        rd_if.read_data  = rnd256();
        step();
        cyc++;
      end
      rd_if.read_ready = 1'b0;
      rd_if.read_end   = 1'b0;
    end
    chk("done_pulse", done, 1'b1);
    chk("busy_done", busy, 1'b1);
    chk("beat_count", beat_count, DW'(beats_tot));
    chk("cycle_count", cycle_count, DW'(cyc));
    chk("error", error, exp_err);
    chk("checksum", checksum, exp_checksum(sum));
    step();
    chk("done_cleared", done, 1'b0);
    chk("busy_cleared", busy, 1'b0);
    chk("beat_hold", beat_count, DW'(beats_tot));
  endtask

  initial begin
    rd_if.read_ready = 1'b0;
    rd_if.read_end   = 1'b0;
    rd_if.read_data  = '0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_start", rd_if.start_read, 1'b0);
    chk("rst_addr", rd_if.read_addr, '0);
    chk("rst_beats", beat_count, '0);
    chk("rst_cycles", cycle_count, '0);
    chk("rst_checksum", checksum, '0);
    resetn = 1'b1;
    step();

    // Nominal strided job, zero-burst job, short burst, address wrap.
    run_job(33'h0_0000_1000, 33'h0_0000_0400, 4, 8'd3, -1, -1, 1'b0);
    run_job(33'h0_0000_2000, 33'h0_0000_0100, 0, 8'd3, -1, -1, 1'b0);
    run_job(33'h0_0000_3000, 33'h0_0000_0400, 2, 8'd3, 0, -1, 1'b0);
    run_job(33'h1_FFFF_FC00, 33'h0_0000_0400, 2, 8'd7, -1, -1, 1'b0);

    // Known beats whose XOR is zero.
    fixed_q.push_back(256'hA5);
    fixed_q.push_back(256'h5A);
    fixed_q.push_back(256'hFF);
    run_job(33'h0_0000_4000, 33'h0_0000_0040, 1, 8'd2, -1, -1, 1'b0);

    // cfg_start pulsed mid-job must not disturb it.
    run_job(33'h0_0001_0000, 33'h0_0000_0800, 3, 8'd1, -1, -1, 1'b1);

    // Reset during WAIT abandons the burst.
    cfg_base_addr  = 33'h0_0000_8000;
    cfg_stride     = 33'h0_0000_0400;
    cfg_num_bursts = 32'd3;
    cfg_burst      = 8'd3;
    cfg_start      = 1'b1;
    step();
    cfg_start = 1'b0;
    step();
    rd_if.read_ready = 1'b1;
    rd_if.read_data  = rnd256();
    step();
    step();
    rd_if.read_ready = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("wrst_busy", busy, 1'b0);
    chk("wrst_beats", beat_count, '0);
    chk("wrst_cycles", cycle_count, '0);
    chk("wrst_addr", rd_if.read_addr, '0);
    chk("wrst_rburst", rd_if.rburst, '0);
    chk("wrst_checksum", checksum, '0);
    step();
    run_job(33'h0_0000_9000, 33'h0_0000_0400, 1, 8'd5, -1, -1, 1'b0);

    // Randomized jobs, including long and short bursts.
    for (int j = 0; j < 8; j++) begin
      run_job({1'($urandom_range(0, 1)), 32'($urandom)}, {1'($urandom_range(0, 1)), 32'($urandom)},
              $urandom_range(1, 4), 8'($urandom_range(0, 7)),
              ($urandom_range(0, 2) == 0) ? 0 : -1, ($urandom_range(0, 3) == 0) ? 1 : -1,
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/read_burst_sequencer.md
# read_burst_sequencer

Upstream command source for the AXI engine's read path. Breaks one programmed read job into a strided sequence of fixed-length bursts. Issues bursts one at a time on the engine's `start_read` / `read_addr` / `rburst` inputs, and consumes the returned `read_data` / `read_ready` / `read_end` stream. Reports beat count, elapsed cycles, a burst-length error flag and an optional data checksum for HBM/DDR4 bandwidth and latency runs.

## Interface
- `ADDR_WIDTH`, 33, byte-address width; must match the engine.
- `DATA_WIDTH`, 256, read data width; must match the engine.
- `LEN_WIDTH`, 8, burst-length field width (AXI `len` encoding, beats = value+1).
- `CNT_WIDTH`, 32, width of the burst, beat and cycle counters.
- `clk` in 1: single clock for the whole block.
- `resetn` in 1: reset, synchronous, active-low.
- `cfg_start` in 1: one-cycle job start; sampled only in IDLE.
- `cfg_base_addr` in ADDR_WIDTH: address of the first burst.
- `cfg_stride` in ADDR_WIDTH: address increment between bursts.
- `cfg_num_bursts` in CNT_WIDTH: number of bursts in the job.
- `cfg_burst` in LEN_WIDTH: burst length, `len` encoding.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse at job completion.
- `error` out 1: sticky; a burst ended with a wrong beat count.
- `beat_count` out CNT_WIDTH: total beats received in the job.
- `cycle_count` out CNT_WIDTH: job duration in cycles.
- `checksum` out DATA_WIDTH: XOR of all beats (see Configuration).
- `start_read` out 1: one-cycle burst request to the engine.
- `read_addr` out ADDR_WIDTH: burst address, held stable while busy.
- `rburst` out LEN_WIDTH: burst length, held stable while busy.
- `read_data` in DATA_WIDTH: beat data from the engine.
- `read_ready` in 1: beat valid.
- `read_end` in 1: one-cycle pulse marking the end of the current burst.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On `cfg_start`, latch all `cfg_*` inputs.
  - Clear `beat_count`, `cycle_count`, `error`, `checksum`, the burst index and the per-burst beat counter.
  - Go to DONE if `cfg_num_bursts`==0, else go to ISSUE.
- ISSUE: `start_read`=1 for exactly this cycle, with `read_addr` = current address and `rburst` = latched burst. Go to WAIT.
- WAIT:
  - Each cycle with `read_ready`=1 increments the per-burst beat counter and `beat_count`.
  - On `read_end`:
    - Compare the per-burst count, including any beat in the same cycle, against `rburst`+1. On mismatch, set `error`.
    - Clear the per-burst counter and increment the burst index.
    - If the index equals the latched `cfg_num_bursts`, go to DONE.
    - Otherwise set address = address + stride, mod 2^ADDR_WIDTH, and go to ISSUE.
- DONE: `done`=1 for one cycle, then go to IDLE. Results hold until the next accepted `cfg_start`.
- `busy`=1 in ISSUE, WAIT and DONE.
- `cfg_start` while busy is ignored.
- `read_ready` or `read_end` outside WAIT is ignored: not counted, no error.
- `cycle_count` increments every cycle in ISSUE and WAIT and saturates at all-ones. `beat_count` wraps.

## Timing
- All outputs are registered. Reset values: `start_read`=0, `done`=0, `busy`=0, `error`=0, `read_addr`=0, `rburst`=0, all counters 0, `checksum`=0. FSM resets to IDLE.
- `cfg_start` at cycle T gives `start_read`=1 at T+1.
- `read_end` at cycle T gives the next `start_read` at T+1, or `done` at T+1 for the last burst.
- A zero-burst job gives `done` at T+1 after `cfg_start` at T, with `start_read` never asserted.
- `resetn` low in any state: outputs return to reset values on the next edge. An in-flight burst is abandoned; the engine is reset alongside.

## Configuration
- Macro `READ_SEQ_CHECKSUM_EN`.
- Defined: `checksum` accumulates the XOR of every accepted `read_data` beat in WAIT.
- Undefined: no accumulator is built and `checksum` is tied to 0.

## Test plan
- Base 0x1000, stride 0x400, 4 bursts, `cfg_burst`=3, engine returns 4 beats then `read_end` -> addresses 0x1000/0x1400/0x1800/0x1C00, `beat_count`=16, `error`=0, one `done` pulse.
- `cfg_num_bursts`=0 -> `done` one cycle after start, no `start_read`, `cycle_count`=0.
- Burst returns 3 beats with `cfg_burst`=3 -> `error`=1 and the job still completes.
- Base 0x1_FFFF_FC00, stride 0x400, 2 bursts, ADDR_WIDTH 33 -> second address wraps to 0x0.
- Beats 0xA5, 0x5A, 0xFF with the macro defined -> `checksum`=0x00. With the macro undefined -> 0.
- `resetn` low during WAIT, then restart with 1 burst -> clean job, `beat_count`=`cfg_burst`+1. `cfg_start` pulsed while busy -> ignored.
